// File: rtl/router_pkg.sv
// Shared types for the router input buffer: packet-parsing states and the flit type.
package router_pkg;

    localparam int FLIT_W_DEFAULT = 16;

    typedef logic [FLIT_W_DEFAULT-1:0] flit_t;

    typedef enum logic [2:0] {
        B_IDLE    = 3'd0,
        B_REQ     = 3'd1,
        B_HEADER  = 3'd2,
        B_SIZE    = 3'd3,
        B_PAYLOAD = 3'd4
    } buffer_state;

endpackage

// File: rtl/router_input_buffer_fifo_sync.sv
// Synchronous FIFO with registered occupancy count; pointers wrap naturally
// because DEPTH is a power of two.
module fifo_sync #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // Storage, pointers and count; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_input_buffer.sv
// Router input port: buffers incoming flits, requests an output port for the
// packet at the head, then streams header, size and payload under credit.
module router_input_buffer
    import router_pkg::*;
#(
    parameter int FLIT_WIDTH   = 16,
    parameter int BUFFER_DEPTH = 4,
    localparam int PTR_WIDTH   = $clog2(BUFFER_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [FLIT_WIDTH-1:0] data_i,
    output logic                  credit_o,
    output logic                  req_o,
    output logic [FLIT_WIDTH-1:0] dest_o,
    input  logic                  grant_i,
    output logic                  tx,
    output logic [FLIT_WIDTH-1:0] data_o,
    input  logic                  credit_i,
    output logic                  eop_o,
    output logic                  busy_o,
    output logic                  overflow_o
);

    buffer_state           state;
    buffer_state           state_nxt;
    logic [FLIT_WIDTH-1:0] head;
    logic [FLIT_WIDTH-1:0] size_cnt;
    logic [PTR_WIDTH:0]    count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  streaming;
    logic                  last_flit;

    fifo_sync #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (data_i),
        .data_out (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // credit comes straight from the registered count, so no combinational path from rx
    assign credit_o  = (count != (PTR_WIDTH+1)'(BUFFER_DEPTH));
    assign push      = rx && credit_o;
    assign streaming = (state == B_HEADER) || (state == B_SIZE) || (state == B_PAYLOAD);
    assign tx        = streaming && !empty;
    assign pop       = tx && credit_i;
    assign last_flit = ((state == B_SIZE) && (head == '0)) ||
                       ((state == B_PAYLOAD) && (size_cnt == FLIT_WIDTH'(1)));
    assign eop_o     = pop && last_flit;
    assign req_o     = (state == B_REQ);
    assign dest_o    = req_o ? head : '0;
    assign data_o    = head;
    assign busy_o    = (state != B_IDLE);

    // Packet walk: an empty FIFO mid-packet simply holds the state.
    always_comb begin
        state_nxt = state;
        case (state)
            B_IDLE:    if (!empty)  state_nxt = B_REQ;
            B_REQ:     if (grant_i) state_nxt = B_HEADER;
            B_HEADER:  if (pop)     state_nxt = B_SIZE;
            B_SIZE:    if (pop)     state_nxt = (head == '0) ? B_IDLE : B_PAYLOAD;
            B_PAYLOAD: if (pop && last_flit) state_nxt = B_IDLE;
            default:   state_nxt = B_IDLE;
        endcase
    end

    // State, remaining-payload counter and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= B_IDLE;
            size_cnt   <= '0;
            overflow_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop && (state == B_SIZE)) begin
                size_cnt <= head;
            end else if (pop && (state == B_PAYLOAD)) begin
                size_cnt <= size_cnt - 1'b1;
            end
            if (rx && !credit_o) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: a flit-queue model tracks buffer contents,
// the forwarding order, packet boundaries and the sticky overflow flag.
module tb_router_input_buffer;

    localparam int FW = 16;
    localparam int D  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          rx;
    logic [FW-1:0] data_i;
    logic          credit_o;
    logic          req_o;
    logic [FW-1:0] dest_o;
    logic          grant_i;
    logic          tx;
    logic [FW-1:0] data_o;
    logic          credit_i;
    logic          eop_o;
    logic          busy_o;
    logic          overflow_o;

    router_input_buffer #(.FLIT_WIDTH(FW), .BUFFER_DEPTH(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .data_i     (data_i),
        .credit_o   (credit_o),
        .req_o      (req_o),
        .dest_o     (dest_o),
        .grant_i    (grant_i),
        .tx         (tx),
        .data_o     (data_o),
        .credit_i   (credit_i),
        .eop_o      (eop_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always #5 clock = ~clock;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [FW-1:0] q[$];
    logic [FW-1:0] src[$];
    bit            m_ovf = 0;
    bit            granted = 0;
    int            m_pos = 0;
    int            m_rem = 0;
    int            eop_seen = 0;
    int            m_xfer = 0;
    logic [FW-1:0] last_eop_data = '0;
    bit            feed_force = 0;
    int            rx_pct = 100;
    int            g_pct = 0;
    int            c_pct = 100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s mismatch", tag);
        end
    endtask

    // Compare outputs against the model mid-cycle, then advance the model
    // to what the coming clock edge should do.
    task automatic sample();
        int            pre;
        logic [FW-1:0] f;
        bit            exp_e;
        @(negedge clock);
        if (reset) begin
            q.delete();
            m_ovf = 0; granted = 0; m_pos = 0; m_rem = 0;
            return;
        end
        pre = q.size();
        chk("credit_o", credit_o, (pre != D) ? 1 : 0);
        chk("overflow_o", overflow_o, m_ovf ? 1 : 0);
        chk("tx", tx, (granted && pre > 0) ? 1 : 0);
        chk("req_o_when_busy", (req_o && (granted || pre == 0)) ? 1 : 0, 0);
        if (tx && pre > 0) chk("data_o_head", data_o, q[0]);
        if (tx && credit_i && pre > 0) begin
            f = q.pop_front();
            m_xfer++;
            exp_e = 0;
            case (m_pos)
                0: m_pos = 1;
                1: if (f == 0) begin exp_e = 1; m_pos = 0; end
                   else begin m_rem = int'(f); m_pos = 2; end
                default: begin
                    exp_e = (m_rem == 1);
                    m_rem--;
                    if (m_rem == 0) m_pos = 0;
                end
            endcase
            chk("eop_o", eop_o, exp_e ? 1 : 0);
            if (exp_e) begin
                granted = 0;
                eop_seen++;
                last_eop_data = f;
            end
        end else begin
            chk("eop_o_no_xfer", eop_o, 0);
        end
        if (req_o && grant_i) granted = 1;
        if (rx) begin
            if (pre < D) q.push_back(data_i);
            else m_ovf = 1;
            void'(src.pop_front());
        end
    endtask

    task automatic drive();
        rx       = !reset && src.size() > 0 && (feed_force || credit_o) &&
                   ($urandom_range(99) < rx_pct);
        data_i   = (src.size() > 0) ? src[0] : '0;
        grant_i  = $urandom_range(99) < g_pct;
        credit_i = $urandom_range(99) < c_pct;
    endtask

    task automatic step();
        sample();
        @(posedge clock);
        #1;
        drive();
    endtask

    initial begin
        int e0;
        int x0;
        int gap;
        int sz;
        reset = 1'b1; rx = 1'b0; data_i = '0; grant_i = 1'b0; credit_i = 1'b1;
        step(); step();
        reset = 1'b0;
        drive();
        chk("rst_credit_o", credit_o, 1);
        chk("rst_req_o", req_o, 0);
        chk("rst_tx", tx, 0);
        chk("rst_eop_o", eop_o, 0);
        chk("rst_busy_o", busy_o, 0);
        chk("rst_overflow_o", overflow_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_dest_o", dest_o, 0);

        // basic packet and request latency
        src = '{16'h0102, 16'h0002, 16'hAAAA, 16'hBBBB};
        g_pct = 0; c_pct = 100; rx_pct = 100;
        drive();
        step();
        chk("lat_req_n1", req_o, 0);
        step();
        chk("lat_req_n2", req_o, 1);
        chk("lat_dest", dest_o, 16'h0102);
        grant_i = 1'b1;
        step();
        chk("lat_tx_n3", tx, 1);
        chk("lat_data_n3", data_o, 16'h0102);
        chk("lat_req_drop", req_o, 0);
        for (int i = 0; i < 20 && eop_seen < 1; i++) step();
        chk("pkt1_done", eop_seen, 1);
        chk("pkt1_eop_flit", last_eop_data, 16'hBBBB);
        step();
        chk("pkt1_busy_after", busy_o, 0);

        // grant held off, then a zero-size packet
        src = '{16'h0500, 16'h0000};
        g_pct = 0;
        drive();
        step(); step(); step();
        for (int i = 0; i < 10; i++) begin
            chk("hold_req", req_o, 1);
            chk("hold_tx", tx, 0);
            chk("hold_dest", dest_o, 16'h0500);
            step();
        end
        g_pct = 100;
        for (int i = 0; i < 20 && eop_seen < 2; i++) step();
        chk("size0_done", eop_seen, 2);
        chk("size0_eop_flit", last_eop_data, 16'h0000);
        step();
        chk("size0_busy_after", busy_o, 0);

        // downstream stalled: fill, overflow, drain
        src = '{16'h0700, 16'h0004, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        c_pct = 0; g_pct = 100; feed_force = 1;
        drive();
        step(); step(); step(); step();
        chk("full_credit_o", credit_o, 0);
        chk("full_no_ovf", overflow_o, 0);
        step();
        chk("ovf_set", overflow_o, 1);
        step();
        feed_force = 0; c_pct = 100;
        drive();
        x0 = m_xfer;
        for (int i = 0; i < 10; i++) step();
        chk("drain_count", m_xfer - x0, 4);
        chk("ovf_sticky", overflow_o, 1);
        reset = 1'b1;
        drive();
        step();
        reset = 1'b0;
        drive();
        chk("ovf_cleared", overflow_o, 0);
        chk("ovf_rst_busy", busy_o, 0);

        // back-to-back packets, pointers wrap
        src = '{16'h0901, 16'h0001, 16'hC001, 16'h0A02, 16'h0002, 16'hD001, 16'hD002};
        g_pct = 100; c_pct = 100;
        drive();
        e0 = eop_seen;
        for (int i = 0; i < 40 && eop_seen < e0 + 1; i++) step();
        chk("b2b_first_done", eop_seen, e0 + 1);
        gap = 0;
        while (!req_o && gap < 5) begin
            step();
            gap++;
        end
        chk("b2b_gap", gap, 1);
        for (int i = 0; i < 40 && eop_seen < e0 + 2; i++) step();
        chk("b2b_second_done", eop_seen, e0 + 2);
        chk("b2b_last_flit", last_eop_data, 16'hD002);

        // reset in the middle of the payload
        src = '{16'h0300, 16'h0005, 16'h5001, 16'h5002, 16'h5003, 16'h5004, 16'h5005};
        drive();
        e0 = eop_seen;
        for (int i = 0; i < 40 && !(m_pos == 2 && m_rem == 3); i++) step();
        chk("mid_reached", (m_pos == 2 && m_rem == 3) ? 1 : 0, 1);
        reset = 1'b1;
        src.delete();
        drive();
        step();
        reset = 1'b0;
        drive();
        chk("mid_credit_o", credit_o, 1);
        chk("mid_tx", tx, 0);
        chk("mid_busy_o", busy_o, 0);
        chk("mid_eop_o", eop_o, 0);
        chk("mid_no_eop", eop_seen, e0);

        // randomized traffic
        rx_pct = 70; g_pct = 50; c_pct = 60;
        for (int p = 0; p < 15; p++) begin
            sz = $urandom_range(5);
            src.push_back(FW'($urandom));
            src.push_back(FW'(sz));
            for (int k = 0; k < sz; k++) src.push_back(FW'($urandom));
        end
        drive();
        e0 = eop_seen;
        for (int i = 0; i < 3000 && eop_seen < e0 + 15; i++) step();
        chk("rand_done", eop_seen, e0 + 15);
        step();
        chk("rand_idle", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/router_input_buffer.md
Name: router_input_buffer

Overview:
- Router-side counterpart of the ddma transmit path: accepts flits pushed by a DMA/neighbour over the credit-based port and buffers them in a FIFO.
- Parses each packet as header flit, size flit, then payload flits.
- Requests an output port from the switch allocator and forwards the packet flit-by-flit to the crossbar under downstream credit.
- One instance per router input port.

Parameters:
- FLIT_WIDTH, 16, width of one flit; the header flit carries the destination address.
- BUFFER_DEPTH, 4, FIFO entries; power of two, 2..64.
- PTR_WIDTH, $clog2(BUFFER_DEPTH), pointer width; derived, not overridden.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx  input  1  upstream flit valid
- data_i  input  FLIT_WIDTH  upstream flit
- credit_o  output  1  buffer can accept a flit this cycle
- req_o  output  1  routing request to the switch allocator
- dest_o  output  FLIT_WIDTH  header flit of the packet at the FIFO head
- grant_i  input  1  allocator grant for req_o
- tx  output  1  downstream flit valid
- data_o  output  FLIT_WIDTH  downstream flit (FIFO head)
- credit_i  input  1  downstream can accept a flit
- eop_o  output  1  one-cycle pulse on the last flit of a packet
- busy_o  output  1  packet in flight (state != B_IDLE)
- overflow_o  output  1  sticky; set when rx=1 while credit_o=0

Behaviour:
- Reset: the FIFO is flushed (pointers and count 0).
  - FSM goes to B_IDLE and the payload counter to 0.
  - credit_o=1 the cycle after reset is deasserted; all other outputs are 0.
  - Reset mid-packet discards all buffered flits, with no eop_o.
- Write side:
  - credit_o = (count != BUFFER_DEPTH), decoded from registered count.
  - Push when rx && credit_o.
  - rx && !credit_o drops the flit and sets overflow_o until reset.
- Simultaneous push and pop with a non-full FIFO leaves count unchanged. The pointers wrap modulo BUFFER_DEPTH.
- Read side: data_o is always the FIFO head. Pop when tx && credit_i.
- FSM states and transitions:
  - B_IDLE: moves to B_REQ when the FIFO is not empty.
  - B_REQ: req_o=1 and dest_o=head. On grant_i=1, moves to B_HEADER next cycle; req_o drops that same next cycle.
  - B_HEADER: tx=!empty. On transfer, moves to B_SIZE.
  - B_SIZE: tx=!empty.
    - On transfer, counter <= data_o.
    - If data_o==0, pulse eop_o and move to B_IDLE; otherwise move to B_PAYLOAD.
  - B_PAYLOAD: tx=!empty. Each transfer decrements the counter.
    - On the transfer with counter==1, pulse eop_o and move to B_IDLE.
- Latency: a header written at cycle N into an empty buffer gives req_o=1 at N+2. With grant at N+2 and credit_i=1, the header leaves at N+3.
- Empty FIFO mid-packet: tx=0 and the FSM holds its state. Flits are never skipped.
- credit_i=0: tx stays asserted, data_o stays stable and no pop happens.
- The size counter is FLIT_WIDTH bits and is unsigned.
- Back-to-back packets: B_IDLE re-enters B_REQ the next cycle if the next header is already buffered.

Decomposition:
- router_pkg: typedef enum buffer_state {B_IDLE, B_REQ, B_HEADER, B_SIZE, B_PAYLOAD}; typedef logic [FLIT_WIDTH-1:0] flit_t.
- Sub-module fifo_sync (parameters WIDTH, DEPTH): push, pop, data_out, full, empty, count. The FSM and counter stay in router_input_buffer.

Test Plan:
- Reset, then push header 0x0102, size 0x0002, payloads 0xAAAA and 0xBBBB; grant at the first req_o; credit_i=1 -> req_o at N+2, dest_o=0x0102, data_o sequence 0x0102, 0x0002, 0xAAAA, 0xBBBB, eop_o with 0xBBBB, busy_o low afterwards.
- Size 0x0000 packet -> two flits forwarded, eop_o on the size flit, FSM returns to B_IDLE.
- credit_i=0 with a 6-flit packet, BUFFER_DEPTH=4 -> credit_o low after 4 pushes; a 5th rx sets overflow_o; releasing credit_i drains 4 flits in order.
- Hold grant_i=0 for 10 cycles -> req_o stays 1, tx=0, dest_o stable.
- Two packets back-to-back with continuous credit -> no bubble between eop_o and the second req_o beyond one cycle; the pointers wrap correctly.
- Assert reset mid-payload (counter=3) -> next cycle credit_o=1, tx=0, busy_o=0, no eop_o; a fresh packet then forwards correctly.
